// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage feeding the ALU: decodes OP, OP-IMM, LUI, AUIPC into registered
// operands/opcode behind a valid/ready register with flush. Optional forwarding: ALU_DECODE_FORWARD_EN.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        instr_valid_in,
    output logic        instr_ready_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    input  logic        flush_in,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  opcode_out,
    output logic [4:0]  rd_out,
    output logic        reg_we_out,
    output logic        illegal_out,
    output logic        valid_out,
    input  logic        ready_in
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;
    localparam int unsigned OPW  = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] op_1;
        logic [XLEN-1:0] op_2;
        logic [OPW-1:0]  opcode;
        logic [RAW-1:0]  rd;
        logic            reg_we;
        logic            illegal;
    } dec_t;

    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    dec_t            dec;
    dec_t            dec_q;
    logic            legal;
    logic            valid_q;

    assign opc          = instr_in[6:0];
    assign funct3       = instr_in[14:12];
    assign funct7       = instr_in[31:25];
    assign rs1_addr_out = instr_in[19:15];
    assign rs2_addr_out = instr_in[24:20];

    // Source operand selection; x0 always reads as zero, even over a forwarded value.
`ifdef ALU_DECODE_FORWARD_EN
    logic fwd_1;
    logic fwd_2;
    assign fwd_1   = wb_en_in && (wb_addr_in != '0) && (wb_addr_in == rs1_addr_out);
    assign fwd_2   = wb_en_in && (wb_addr_in != '0) && (wb_addr_in == rs2_addr_out);
    assign rs1_val = (rs1_addr_out == '0) ? '0 : (fwd_1 ? wb_data_in : rs1_data_in);
    assign rs2_val = (rs2_addr_out == '0) ? '0 : (fwd_2 ? wb_data_in : rs2_data_in);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en_in, wb_addr_in, wb_data_in};
    assign rs1_val   = (rs1_addr_out == '0) ? '0 : rs1_data_in;
    assign rs2_val   = (rs2_addr_out == '0) ? '0 : rs2_data_in;
`endif

    // Instruction decode; anything not recognised collapses to an illegal bubble with zero operands.
    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.rd = instr_in[11:7];
        case (opc)
            OPC_OP: begin
                legal      = (funct7 == F7_ZERO) ||
                             ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.op_1   = rs1_val;
                dec.op_2   = rs2_val;
                dec.opcode = {funct7[5], funct3};
            end
            OPC_OP_IMM: begin
                dec.op_1 = rs1_val;
                case (funct3)
                    3'b001: begin
                        legal      = (funct7 == F7_ZERO);
                        dec.op_2   = XLEN'(instr_in[24:20]);
                        dec.opcode = 4'b0001;
                    end
                    3'b101: begin
                        legal      = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec.op_2   = XLEN'(instr_in[24:20]);
                        dec.opcode = {funct7[5], 3'b101};
                    end
                    default: begin
                        legal      = 1'b1;
                        dec.op_2   = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
                        dec.opcode = {1'b0, funct3};
                    end
                endcase
            end
            OPC_LUI: begin
                legal    = 1'b1;
                dec.op_2 = {instr_in[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                dec.op_1 = pc_in;
                dec.op_2 = {instr_in[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op_1   = '0;
            dec.op_2   = '0;
            dec.opcode = '0;
        end
        dec.illegal = !legal;
        dec.reg_we  = legal && (dec.rd != '0);
    end

    assign instr_ready_out = (!valid_q || ready_in) && !flush_in;

    // Pipeline register: flush kills, transfer loads, consume without refill drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else if (flush_in) begin
            valid_q <= 1'b0;
        end else if (instr_valid_in && instr_ready_out) begin
            valid_q <= 1'b1;
            dec_q   <= dec;
        end else if (ready_in) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_out   = valid_q;
    assign op_1_out    = dec_q.op_1;
    assign op_2_out    = dec_q.op_2;
    assign opcode_out  = dec_q.opcode;
    assign rd_out      = dec_q.rd;
    assign reg_we_out  = dec_q.reg_we;
    assign illegal_out = dec_q.illegal;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed instructions, stall, flush, forwarding and reset.
module tb_alu_decode_stage;
    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  opcode;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in, pc_in, rs1_data_in, rs2_data_in, wb_data_in;
    logic        instr_valid_in, instr_ready_out, wb_en_in, flush_in, ready_in;
    logic [4:0]  rs1_addr_out, rs2_addr_out, wb_addr_in, rd_out;
    logic [31:0] op_1_out, op_2_out;
    logic [3:0]  opcode_out;
    logic        reg_we_out, illegal_out, valid_out;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .flush_in(flush_in), .op_1_out(op_1_out), .op_2_out(op_2_out),
        .opcode_out(opcode_out), .rd_out(rd_out), .reg_we_out(reg_we_out),
        .illegal_out(illegal_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: whenever the execute stage consumes an output, compare it to the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got op_1=0x%08h with empty scoreboard", op_1_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("op_1", op_1_out, e.op_1);
                check("op_2", op_2_out, e.op_2);
                check("opcode", 32'(opcode_out), 32'(e.opcode));
                check("rd", 32'(rd_out), 32'(e.rd));
                check("reg_we", 32'(reg_we_out), 32'(e.we));
                check("illegal", 32'(illegal_out), 32'(e.ill));
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] o1, input logic [31:0] o2, input logic [3:0] opc,
                                input logic [4:0] rd, input logic we, input logic ill);
        exp_t e;
        e.op_1 = o1; e.op_2 = o2; e.opcode = opc; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    // Present one instruction for a cycle; called #1 after a rising edge, returns #1 after the next.
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic rdy, input exp_t e);
        instr_in = ins; pc_in = pc; rs1_data_in = r1; rs2_data_in = r2;
        instr_valid_in = 1'b1; ready_in = rdy;
        #1;
        if (instr_ready_out) exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] ADD_X3 = 32'h002081B3;
    logic [31:0] fwd_exp;

    initial begin
        rst_n = 1'b0; instr_in = '0; pc_in = '0; instr_valid_in = 1'b0;
        rs1_data_in = '0; rs2_data_in = '0; wb_en_in = 1'b0; wb_addr_in = '0;
        wb_data_in = '0; flush_in = 1'b0; ready_in = 1'b0;
        #12;
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_op_1", op_1_out, 32'd0);
        check("reset_op_2", op_2_out, 32'd0);
        check("reset_misc", {21'd0, opcode_out, rd_out, reg_we_out, illegal_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back directed vectors with ready_in held high
        drive(ADD_X3,       32'h0,   32'd5,  32'd7, 1'b1, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0));
        check("latency_valid", 32'(valid_out), 32'd1);
        drive(32'h402081B3, 32'h0,   32'd5,  32'd7, 1'b1, mk(32'd5, 32'd7, 4'h8, 5'd3, 1'b1, 1'b0));
        drive(32'h40435293, 32'h0,   32'h80, 32'd0, 1'b1, mk(32'h80, 32'd4, 4'hD, 5'd5, 1'b1, 1'b0));
        drive(32'hFFF00093, 32'h0,   32'h55, 32'd0, 1'b1, mk(32'd0, 32'hFFFFFFFF, 4'h0, 5'd1, 1'b1, 1'b0));
        drive(32'h123450B7, 32'h0,   32'h11, 32'h22, 1'b1, mk(32'd0, 32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0));
        drive(32'h00001117, 32'h100, 32'h11, 32'h22, 1'b1, mk(32'h100, 32'h1000, 4'h0, 5'd2, 1'b1, 1'b0));
        drive(32'h00000000, 32'h0,   32'h11, 32'h22, 1'b1, mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b0, 1'b1));
        drive(32'h022081B3, 32'h0,   32'd5,  32'd7, 1'b1, mk(32'd0, 32'd0, 4'h0, 5'd3, 1'b0, 1'b1));
        drive(32'h00208033, 32'h0,   32'd5,  32'd7, 1'b1, mk(32'd5, 32'd7, 4'h0, 5'd0, 1'b0, 1'b0));
        drive(32'h002001B3, 32'h0,   32'h99, 32'd7, 1'b1, mk(32'd0, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0));
        drive(32'h01F11093, 32'h0,   32'h40, 32'd0, 1'b1, mk(32'h40, 32'd31, 4'h1, 5'd1, 1'b1, 1'b0));
        drive(32'h41F11093, 32'h0,   32'h40, 32'd0, 1'b1, mk(32'd0, 32'd0, 4'h0, 5'd1, 1'b0, 1'b1));

        // Forwarding from write-back
`ifdef ALU_DECODE_FORWARD_EN
        fwd_exp = 32'hAA;
`else
        fwd_exp = 32'd5;
`endif
        wb_en_in = 1'b1; wb_addr_in = 5'd1; wb_data_in = 32'hAA;
        drive(ADD_X3, 32'h0, 32'd5, 32'd7, 1'b1, mk(fwd_exp, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0));
        wb_addr_in = 5'd0;
        drive(ADD_X3, 32'h0, 32'd5, 32'd7, 1'b1, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0));
        wb_en_in = 1'b0;
        instr_valid_in = 1'b0;
        @(posedge clk); #1;

        // Backpressure: load ADD with ready_in low, then hold for three cycles
        drive(ADD_X3, 32'h0, 32'd5, 32'd7, 1'b0, mk(32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0));
        instr_in = 32'h402081B3; rs1_data_in = 32'd9; rs2_data_in = 32'd1;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(instr_ready_out), 32'd0);
            check("stall_valid", 32'(valid_out), 32'd1);
            check("stall_op_1", op_1_out, 32'd5);
            check("stall_opcode", 32'(opcode_out), 32'd0);
            @(posedge clk); #1;
        end
        drive(32'h402081B3, 32'h0, 32'd9, 32'd1, 1'b1, mk(32'd9, 32'd1, 4'h8, 5'd3, 1'b1, 1'b0));
        check("release_valid", 32'(valid_out), 32'd1);
        check("release_opcode", 32'(opcode_out), 32'd8);

        // Flush while stalled with another instruction on the input
        drive(ADD_X3, 32'h0, 32'd3, 32'd4, 1'b0, mk(32'd3, 32'd4, 4'h0, 5'd3, 1'b1, 1'b0));
        instr_in = 32'h40435293; flush_in = 1'b1;
        #1;
        check("flush_ready", 32'(instr_ready_out), 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0; instr_valid_in = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        check("flush_valid", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        check("flush_no_accept", 32'(valid_out), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(32'h123450B7, 32'h0, 32'd0, 32'd0, 1'b0, mk(32'd0, 32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0));
        instr_valid_in = 1'b0;
        check("pre_reset_valid", 32'(valid_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        check("mid_reset_valid", 32'(valid_out), 32'd0);
        check("mid_reset_op_2", op_2_out, 32'd0);
        check("mid_reset_misc", {21'd0, opcode_out, rd_out, reg_we_out, illegal_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_in = 1'b1;

        // Bounded drain: every pushed expectation must have been consumed
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode/issue stage directly upstream of the ALU. Accepts one RV32I instruction per cycle with its PC and register-file read data. Produces registered `op_1`, `op_2`, 4-bit ALU opcode and destination info for the execute stage. Uses a valid/ready pipeline register with flush and optional write-back forwarding.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register address, 4-bit ALU opcode.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_in` input 32: instruction word.
- `pc_in` input 32: PC of `instr_in`.
- `instr_valid_in` input 1: upstream holds a valid instruction.
- `instr_ready_out` output 1: stage accepts this cycle.
- `rs1_addr_out` output 5: combinational `instr_in[19:15]`, sent to the register file.
- `rs2_addr_out` output 5: combinational `instr_in[24:20]`, sent to the register file.
- `rs1_data_in` input 32: register-file read data for rs1, same cycle.
- `rs2_data_in` input 32: register-file read data for rs2, same cycle.
- `wb_en_in` input 1: write-back write enable, used for forwarding.
- `wb_addr_in` input 5: write-back destination register.
- `wb_data_in` input 32: write-back data.
- `flush_in` input 1: kill held and incoming instruction.
- `op_1_out` output 32: ALU operand 1.
- `op_2_out` output 32: ALU operand 2.
- `opcode_out` output 4: ALU opcode.
- `rd_out` output 5: destination register.
- `reg_we_out` output 1: result must be written back.
- `illegal_out` output 1: instruction not supported.
- `valid_out` output 1: output register holds an instruction.
- `ready_in` input 1: execute stage consumes the instruction this cycle.

## Operation
- Supported instruction classes and decode:
  - OP (opcode 0110011): `opcode_out={funct7[5],funct3}`. Legal when funct7=0000000, or when funct7=0100000 with funct3 000 (sub→1000) or 101 (sra→1101). Operands are rs1 and rs2.
  - OP-IMM (0010011): `op_2` = sign-extended imm[11:0], `opcode_out={0,funct3}`.
    - For funct3 001 and 101, `op_2={27'b0,shamt}`.
    - slli and srli require funct7=0000000.
    - srai (funct7=0100000, funct3 101) gives `opcode_out` 1101.
    - Any other funct7 on a shift is illegal.
  - LUI (0110111): `op_1=0`, `op_2={imm[31:12],12'b0}`, opcode 0000.
  - AUIPC (0010111): `op_1=pc_in`, `op_2={imm[31:12],12'b0}`, opcode 0000.
- Destination: `rd_out=instr[11:7]`. `reg_we_out=1` for legal instructions with rd≠0, otherwise 0.
- Illegal or unsupported instructions: still pass through with `illegal_out=1`, `reg_we_out=0`, opcode 0000, operands 0.
- Register x0: a source address of 0 always yields operand 0, whatever the read data.
- Forwarding: see Configuration.

## Timing
- Reset: all registered outputs are 0 (`op_1_out`, `op_2_out`, `opcode_out`, `rd_out`, `reg_we_out`, `illegal_out`, `valid_out`).
- Latency: exactly 1 cycle from acceptance to `valid_out`.
- Ready: `instr_ready_out = (!valid_out || ready_in) && !flush_in`, combinational.
- Transfer: a transfer occurs when `instr_valid_in && instr_ready_out`. The output register loads decoded values and `valid_out` becomes 1.
- Drain: if `ready_in` is high with no new transfer, `valid_out` becomes 0.
- Stall: while `valid_out && !ready_in`, all outputs hold stable.
- Flush: `flush_in` has priority over everything. Next cycle `valid_out=0`, and any input presented that cycle is dropped.
- Reset asserted mid-stall clears `valid_out` immediately; the held instruction is lost.
- Back-to-back: with `ready_in` held at 1, one instruction per cycle.

## Configuration
- Macro `ALU_DECODE_FORWARD_EN`.
- Defined: if `wb_en_in && wb_addr_in!=0 && wb_addr_in==rsN`, the operand uses `wb_data_in` instead of `rsN_data_in`. The x0 rule still forces 0.
- Undefined: the `wb_*` ports exist but are ignored, and operands come directly from `rs*_data_in`.

## Test plan
- Basic R-type and sub:
  - ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 → next cycle: valid_out=1, op_1=5, op_2=7, opcode 0000, rd=3, reg_we=1.
  - SUB 0x402081B3 → opcode 1000.
- Immediates:
  - SRAI x5,x6,4 (0x40435293) → op_2=4, opcode 1101.
  - ADDI x1,x0,-1 (0xFFF00093) with rs1_data=0x55 → op_1=0, op_2=0xFFFFFFFF.
  - LUI x1,0x12345 (0x123450B7) → op_1=0, op_2=0x12345000.
  - AUIPC with pc=0x100 → op_1=0x100.
- Illegal: 0x00000000 → illegal_out=1, reg_we=0, valid_out=1. ADD with funct7=0000001 → illegal_out=1.
- Backpressure: valid_out=1 with ready_in=0 for 3 cycles → outputs stable and instr_ready_out=0. Raising ready_in with a new instruction present → new instruction appears next cycle.
- Flush: flush_in pulse while stalled, with an instruction on the input → valid_out=0 next cycle and no instruction is accepted.
- Forwarding: ADD x3,x1,x2 with wb_en=1, wb_addr=1, wb_data=0xAA, rs1_data=5 → op_1=0xAA with the macro defined, 5 without. With wb_addr=0 → op_1=5 in both builds.
- Reset: assert rst_n=0 mid-stall → all outputs 0 immediately.
